// File: rtl/adc_avg_pkg.sv
`default_nettype none
// ============================================================================
// Module : adc_avg_pkg
// Brief  : FSM state encoding, accumulator sizing and window-exponent clamp
// Rev    : 1.0  initial release
// ============================================================================
package adc_avg_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_st_idle   = 2'd0;
    localparam state_t c_st_settle = 2'd1;
    localparam state_t c_st_accum  = 2'd2;
    localparam state_t c_st_output = 2'd3;

    // Accumulator width for the default 12-bit samples and 1024-sample window
    localparam int c_acc_width = 12 + 10;

    function automatic int acc_width(input int adc_width, input int log2_max_samps);
        return adc_width + log2_max_samps;
    endfunction

    function automatic logic [3:0] clamp_log2(input logic [3:0] log2_req,
                                              input logic [3:0] log2_max);
        return (log2_req > log2_max) ? log2_max : log2_req;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_ch_accum.sv
`default_nettype none
// ============================================================================
// Module : adc_ch_accum
// Brief  : Single-channel sample accumulator with floor-divide-by-2^L output
// Rev    : 1.0  initial release
// ============================================================================
module adc_ch_accum #(
    parameter int ADC_WIDTH      = 12,
    parameter int LOG2_MAX_SAMPS = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_clear,
    input  logic                 i_enable,
    input  logic                 i_signed,
    input  logic [ADC_WIDTH-1:0] i_sample,
    input  logic [3:0]           i_shift,
    output logic [ADC_WIDTH-1:0] o_average
);
    import adc_avg_pkg::*;

    localparam int c_acc_w = acc_width(ADC_WIDTH, LOG2_MAX_SAMPS);

    logic [c_acc_w-1:0]        r_acc;
    logic [c_acc_w-1:0]        w_sample_ext;
    logic signed [c_acc_w-1:0] w_acc_signed;
    logic                      w_ext_bit;

    assign w_ext_bit    = i_signed & i_sample[ADC_WIDTH-1];
    assign w_sample_ext = {{LOG2_MAX_SAMPS{w_ext_bit}}, i_sample};
    assign w_acc_signed = $signed(r_acc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_enable) begin
            r_acc <= r_acc + w_sample_ext;
        end
    end

    // Both shifts floor the quotient; the signed one keeps negative averages negative.
    always_comb begin
        if (i_signed) begin
            o_average = ADC_WIDTH'(w_acc_signed >>> i_shift);
        end else begin
            o_average = ADC_WIDTH'(r_acc >> i_shift);
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_multi_average.sv
`default_nettype none
// ============================================================================
// Module : adc_multi_average
// Brief  : Multi-channel windowed ADC averager with settle delay and run control
// Rev    : 1.0  initial release
// ============================================================================
module adc_multi_average #(
    parameter int NUM_CH         = 2,
    parameter int ADC_WIDTH      = 12,
    parameter int LOG2_MAX_SAMPS = 10,
    parameter int CFG_WIDTH      = 32
) (
    input  logic                          ADC_CLK,
    input  logic                          RST_N,
    input  logic                          START,
    input  logic                          ABORT,
    input  logic                          CONTINUOUS,
    input  logic                          SIGNED_MODE,
    input  logic [3:0]                    LOG2_SAMPS,
    input  logic [CFG_WIDTH-1:0]          TIMER_OFFSET,
    input  logic [NUM_CH*ADC_WIDTH-1:0]   ADC_DATA_IN,
    output logic [NUM_CH*ADC_WIDTH-1:0]   AVE_OUT,
    output logic                          AVE_VALID,
    output logic                          DONE,
    output logic                          BUSY
);
    import adc_avg_pkg::*;

    localparam int                 c_cnt_w     = LOG2_MAX_SAMPS;
    localparam logic [3:0]         c_max_log2  = 4'(LOG2_MAX_SAMPS);
    localparam logic [c_cnt_w-1:0] c_full_mask = '1;
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [CFG_WIDTH-1:0] c_cfg_one = CFG_WIDTH'(1);

    state_t                      r_state;
    logic                        r_busy;
    logic                        r_valid;
    logic                        r_done;
    logic                        r_signed;
    logic [3:0]                  r_log2;
    logic [CFG_WIDTH-1:0]        r_timer;
    logic [CFG_WIDTH-1:0]        r_settle_cnt;
    logic [c_cnt_w-1:0]          r_samp_cnt;
    logic [NUM_CH*ADC_WIDTH-1:0] r_ave_out;

    logic [NUM_CH*ADC_WIDTH-1:0] w_ave_next;
    logic [c_cnt_w-1:0]          w_win_mask;
    logic                        w_win_last;
    logic                        w_clear;
    logic                        w_enable;

    // Low L bits set: the sample counter value on the final capture of the window
    assign w_win_mask = c_full_mask >> (c_max_log2 - r_log2);
    assign w_win_last = (r_samp_cnt == w_win_mask);

    assign w_clear  = ABORT
                    | ((r_state == c_st_idle)   & START)
                    | ((r_state == c_st_output) & CONTINUOUS);
    assign w_enable = (r_state == c_st_accum) & ~ABORT;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            adc_ch_accum #(
                .ADC_WIDTH      (ADC_WIDTH),
                .LOG2_MAX_SAMPS (LOG2_MAX_SAMPS)
            ) u_accum (
                .clk       (ADC_CLK),
                .rst_n     (RST_N),
                .i_clear   (w_clear),
                .i_enable  (w_enable),
                .i_signed  (r_signed),
                .i_sample  (ADC_DATA_IN[g*ADC_WIDTH +: ADC_WIDTH]),
                .i_shift   (r_log2),
                .o_average (w_ave_next[g*ADC_WIDTH +: ADC_WIDTH])
            );
        end
    endgenerate

    always_ff @(posedge ADC_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= c_st_idle;
            r_busy       <= 1'b0;
            r_valid      <= 1'b0;
            r_done       <= 1'b0;
            r_signed     <= 1'b0;
            r_log2       <= '0;
            r_timer      <= '0;
            r_settle_cnt <= '0;
            r_samp_cnt   <= '0;
            r_ave_out    <= '0;
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            if (ABORT) begin
                r_state      <= c_st_idle;
                r_busy       <= 1'b0;
                r_settle_cnt <= '0;
                r_samp_cnt   <= '0;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (START) begin
                            r_log2       <= clamp_log2(LOG2_SAMPS, c_max_log2);
                            r_timer      <= TIMER_OFFSET;
                            r_signed     <= SIGNED_MODE;
                            r_busy       <= 1'b1;
                            r_samp_cnt   <= '0;
                            r_settle_cnt <= TIMER_OFFSET;
                            r_state      <= (TIMER_OFFSET == '0) ? c_st_accum : c_st_settle;
                        end
                    end
                    c_st_settle: begin
                        if (r_settle_cnt <= c_cfg_one) begin
                            r_settle_cnt <= '0;
                            r_state      <= c_st_accum;
                        end else begin
                            r_settle_cnt <= r_settle_cnt - c_cfg_one;
                        end
                    end
                    c_st_accum: begin
                        if (w_win_last) begin
                            r_samp_cnt <= '0;
                            r_state    <= c_st_output;
                        end else begin
                            r_samp_cnt <= r_samp_cnt + c_cnt_one;
                        end
                    end
                    c_st_output: begin
                        r_ave_out <= w_ave_next;
                        r_valid   <= 1'b1;
                        if (CONTINUOUS) begin
                            r_settle_cnt <= r_timer;
                            r_state      <= (r_timer == '0) ? c_st_accum : c_st_settle;
                        end else begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= c_st_idle;
                        end
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= c_st_idle;
                    end
                endcase
            end
        end
    end

    assign AVE_OUT   = r_ave_out;
    assign AVE_VALID = r_valid;
    assign DONE      = r_done;
    assign BUSY      = r_busy;

endmodule
`default_nettype wire
